// File: rtl/pipe_stage_chain.sv
// Handshaked inter-stage register chain: DEPTH stages of data + control with valid/ready,
// bubble collapsing, pipeline-wide freeze and flush-to-bubble.
module pipe_stage_chain #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DEPTH  = 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              freeze,
    input  logic              flush,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d [DEPTH];
    logic [CTRL_W-1:0] c [DEPTH];
    logic [DEPTH-1:0]  adv;
    logic              active;
    logic              in_xfer;
    logic              out_xfer;

    // A stage may load when it is empty or anything downstream of it frees a slot.
    always_comb begin : ready_chain
        logic hole;
        hole = out_ready;
        adv  = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            hole   = hole | ~v[i];
            adv[i] = hole;
        end
    end

    assign active    = ~freeze & ~flush;
    assign in_ready  = adv[0] & active;
    assign out_valid = v[DEPTH-1] & active;
    assign out_data  = d[DEPTH-1];
    assign out_ctrl  = c[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Stage registers; bubbles always carry zeroed payload so they act as clean NOPs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v         <= '0;
            occupancy <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d[i] <= '0;
                c[i] <= '0;
            end
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d[i] <= '0;
                c[i] <= '0;
            end
        end else if (!freeze) begin
            if (adv[0]) begin
                v[0] <= in_valid;
                d[0] <= in_valid ? in_data : '0;
                c[0] <= in_valid ? in_ctrl : '0;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i]) begin
                    v[i] <= v[i-1];
                    d[i] <= v[i-1] ? d[i-1] : '0;
                    c[i] <= v[i-1] ? c[i-1] : '0;
                end
            end
            occupancy <= occupancy + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=3 and DEPTH=1) against a queue-based
// model that tracks each entry's position in the chain.
module tb_pipe_stage_chain;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;
    logic        freeze;
    logic        flush;

    logic        ir3, ov3, ir1, ov1;
    logic [31:0] od3, od1;
    logic [7:0]  oc3, oc1;
    logic [1:0]  occ3;
    logic [0:0]  occ1;

    pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .DEPTH(3)) u_chain3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .in_ctrl(in_ctrl), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
        .out_ctrl(oc3), .freeze(freeze), .flush(flush), .occupancy(occ3)
    );

    pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .DEPTH(1)) u_chain1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_ctrl(oc1), .freeze(freeze), .flush(flush), .occupancy(occ1)
    );

    bit          sel;
    logic        obs_ir, obs_ov;
    logic [31:0] obs_od, obs_occ;
    logic [7:0]  obs_oc;

    assign obs_ir  = sel ? ir1 : ir3;
    assign obs_ov  = sel ? ov1 : ov3;
    assign obs_od  = sel ? od1 : od3;
    assign obs_oc  = sel ? oc1 : oc3;
    assign obs_occ = sel ? 32'(occ1) : 32'(occ3);

    typedef struct {
        logic [31:0] data;
        logic [7:0]  ctrl;
        int          pos;
    } ent_t;

    ent_t mq[$];
    ent_t pq[$];
    bit   plan_rdy;
    int   depth;
    int   errors;
    int   checks;
    int   peak;
    int   n_out;
    bit   seen55;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entries slide forward one slot per edge unless blocked by the entry ahead;
    // the head leaves when it sits in the last slot and the consumer is ready.
    task automatic plan(input bit ordy);
        int lim;
        int np;
        pq = mq;
        if (pq.size() > 0 && pq[0].pos == depth - 1 && ordy)
            void'(pq.pop_front());
        lim = depth;
        for (int k = 0; k < pq.size(); k++) begin
            np = pq[k].pos + 1;
            if (np > lim - 1) np = lim - 1;
            pq[k].pos = np;
            lim = np;
        end
        plan_rdy = (pq.size() == 0) || (pq[pq.size()-1].pos >= 1);
    endtask

    task automatic cycle(input bit rs, input bit iv, input logic [31:0] id, input logic [7:0] ic,
                         input bit ordy, input bit frz, input bit fl);
        bit          act;
        bit          head_last;
        bit          e_ir;
        logic [31:0] e_od;
        logic [7:0]  e_oc;
        @(negedge clk);
        rst       = rs;
        in_valid  = iv;
        in_data   = id;
        in_ctrl   = ic;
        out_ready = ordy;
        freeze    = frz;
        flush     = fl;
        #1;
        if (rs) mq.delete();
        act       = !frz && !fl;
        head_last = (mq.size() > 0) && (mq[0].pos == depth - 1);
        e_od      = head_last ? mq[0].data : 32'h0;
        e_oc      = head_last ? mq[0].ctrl : 8'h0;
        plan(ordy);
        e_ir      = act && plan_rdy;
        chk("in_ready", 32'(obs_ir), 32'(e_ir));
        chk("out_valid", 32'(obs_ov), 32'(act && head_last));
        chk("out_data", obs_od, e_od);
        chk("out_ctrl", 32'(obs_oc), 32'(e_oc));
        chk("occupancy", obs_occ, 32'(mq.size()));
        if (obs_ov && ordy) begin
            n_out++;
            if (obs_od == 32'h55) seen55 = 1'b1;
        end
        if (int'(obs_occ) > peak) peak = int'(obs_occ);
        if (!rs) begin
            if (fl) mq.delete();
            else if (!frz) begin
                mq = pq;
                if (iv && e_ir) mq.push_back('{data: id, ctrl: ic, pos: 0});
            end
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'h0, 8'h0, ordy, 1'b0, 1'b0);
    endtask

    task automatic rand_run(input int n);
        for (int k = 0; k < n; k++)
            cycle(($urandom % 64) == 0, 1'($urandom % 2), $urandom, 8'($urandom),
                  ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0);
    endtask

    initial begin
        errors = 0; checks = 0; peak = 0; n_out = 0; seen55 = 1'b0;
        sel = 1'b0; depth = 3;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;

        cycle(1'b1, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);

        // Streaming three entries through an unobstructed DEPTH=3 chain
        peak = 0;
        cycle(1'b0, 1'b1, 32'h11, 8'h01, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h22, 8'h02, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h33, 8'h03, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b1);
        chk("peak_occ", 32'(peak), 32'd3);

        // Back-pressure: fourth entry waits until the head is consumed
        cycle(1'b0, 1'b1, 32'hA1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hA2, 8'h12, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hA3, 8'h13, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hA4, 8'h14, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hA4, 8'h14, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", 32'(obs_ir), 32'd0);
        cycle(1'b0, 1'b1, 32'hA4, 8'h14, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1);

        // Bubble collapse: lone entry travels to the last stage while the consumer stalls
        cycle(1'b0, 1'b1, 32'hAA, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        chk("collapse_data", obs_od, 32'hAA);
        idle(3, 1'b1);

        // Freeze with two entries resident
        cycle(1'b0, 1'b1, 32'hB1, 8'h21, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hB2, 8'h22, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 32'hBF, 8'h2F, 1'b1, 1'b1, 1'b0);
        chk("freeze_occ", obs_occ, 32'd2);
        idle(5, 1'b1);

        // Flush (with freeze) on a full chain drops the offered entry too
        seen55 = 1'b0;
        cycle(1'b0, 1'b1, 32'hC1, 8'h31, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hC2, 8'h32, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hC3, 8'h33, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h55, 8'h55, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_occ", obs_occ, 32'd0);
        chk("flush_ctrl", 32'(obs_oc), 32'd0);
        idle(5, 1'b1);
        chk("flush_drop", 32'(seen55), 32'd0);

        rand_run(400);

        // DEPTH=1: continuous stream with a reset pulse in the middle
        sel = 1'b1; depth = 1;
        cycle(1'b1, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 32'h100 + k, 8'(k), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h1FF, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("rst_out_data", obs_od, 32'd0);
        cycle(1'b0, 1'b1, 32'h200, 8'h40, 1'b1, 1'b0, 1'b0);
        n_out = 0;
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 32'h201 + k, 8'(k + 65), 1'b1, 1'b0, 1'b0);
        chk("tput_d1", 32'(n_out), 32'd10);

        rand_run(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, handshaked successor to the fixed inter-stage pipeline registers (EX/MEM style).
- Carries one data word plus a control bundle through DEPTH register stages with valid/ready flow control and bubble collapsing.
- Supports pipeline-wide freeze (hazard stall) and flush (branch or exception squash) that inserts zeroed bubbles.
- Sits between any two pipeline units; the consumer applies back-pressure via out_ready.

Parameters:
DATA_W, 32, width of data payload (word, e.g. ALU result and store data concatenated by the instantiator)
CTRL_W, 8, width of control bundle (MEM_write, MEM_read, RF_write_en, selects, ALU op ...)
DEPTH, 1, number of register stages, 1..8
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  producer has an entry
in_ready  out  1  chain accepts an entry this cycle
in_data  in  DATA_W  payload
in_ctrl  in  CTRL_W  control bundle
out_valid  out  1  last stage holds an entry presentable to consumer
out_ready  in  1  consumer takes entry this cycle
out_data  out  DATA_W  last-stage payload
out_ctrl  out  CTRL_W  last-stage control bundle
freeze  in  1  hold all stages, block both handshakes
flush  in  1  squash all stages to bubbles
occupancy  out  CNT_W  number of valid stages

Behaviour:
- State: per stage i (0 = input side, DEPTH-1 = output side): v[i], d[i], c[i].
- Reset (async, rst=1): all v, d, c cleared to 0 immediately; out_valid=0, out_data=0, out_ctrl=0, occupancy=0; in_ready follows the combinational rule below (evaluates to 1 when freeze=0 and flush=0).
- Outputs: out_data=d[DEPTH-1], out_ctrl=c[DEPTH-1] (registered); out_valid = v[DEPTH-1] & ~freeze & ~flush.
- Advance rule (combinational, normal mode, freeze=0 and flush=0):
  - adv[DEPTH] = out_ready.
  - adv[i] = ~v[i] | adv[i+1].
  - in_ready = adv[0].
- Stage update on edge where adv[i]=1:
  - Stage 0 loads in_valid/in_data/in_ctrl.
  - Stage i>0 loads stage i-1.
  - When the loaded valid is 0, d and c are written as 0 (bubbles are clean NOPs).
  - Stages with adv[i]=0 hold.
- Bubble collapsing: an entry moves forward into an empty stage even when the consumer stalls. Full throughput is 1 entry/cycle at any DEPTH.
- Latency: entry accepted at edge N appears on out_valid after edge N+DEPTH-1 when unobstructed (DEPTH=1: visible the cycle after acceptance).
- Handshake transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Producer need not hold in_valid until in_ready; entries not accepted are not captured.
- freeze=1 (flush=0):
  - in_ready=0, out_valid=0, all stages hold, occupancy holds.
  - out_data/out_ctrl remain visible.
- flush=1 (priority over freeze):
  - in_ready=0, out_valid=0, no transfers.
  - Next edge: all v, d, c cleared to 0.
  - Entry offered at in_valid that cycle is dropped.
- Occupancy: registered popcount of v, updated each edge.
  - Next value = current + input transfer − output transfer in normal mode; 0 after flush.
  - Range 0..DEPTH.
- Full: occupancy=DEPTH and out_ready=0 ⇒ in_ready=0.
- Simultaneous output and input transfer when full: in_ready=1 via the ready chain, occupancy unchanged.
- Reset asserted mid-transfer discards all entries; first post-reset edge behaves as an empty chain.

Test Plan:
- DEPTH=3, reset then in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_valid first high 2 cycles after the 0x11 acceptance edge, outputs 0x11,0x22,0x33 on consecutive cycles, occupancy peaks at 3.
- DEPTH=3, out_ready=0, stream 4 entries -> the first 3 accepted, in_ready drops to 0 when occupancy=3; raise out_ready -> the 4th entry is accepted in the same cycle the first is taken, order preserved.
- DEPTH=3, one entry 0xAA in stage 0, stages 1-2 empty, out_ready=0 -> 0xAA reaches stage 2 after 2 edges (bubble collapse), then holds.
- Chain holding 2 entries, freeze=1 for 3 cycles with in_valid=1 and out_ready=1 -> no transfers, out_valid=0, occupancy stays 2, and the state is intact after freeze drops.
- Chain full, flush=1 and freeze=1 together for one cycle with in_valid=1 data 0x55 -> next cycle occupancy=0, out_ctrl=0, out_data=0, 0x55 never emerges.
- DEPTH=1, in_valid=1 and out_ready=1 continuously, rst pulsed mid-stream -> outputs zero immediately on rst; after release, 1 entry/cycle throughput resumes.
